axi_sub_mem: RTL and testbench
==============================

Name: axi_sub_mem

Overview:
- AXI4 subordinate memory model: the responder end of the AXI manager bus used in the I3C co-simulation bench.
- Serves reads and writes from an internal word-addressed RAM.
- Provides a memory/peripheral target so manager-side logic (DMA paths, recovery image fetch) can be exercised against a cycle-accurate responder.
- Read and write channels are independent; each handles one outstanding burst at a time.

Parameters:
- AxiAddrWidth, 20, byte address width.
- AxiDataWidth, 64, data width; only 64 is supported.
- AxiIdWidth, 4, transaction ID width.
- MemWords, 1024, RAM depth in 64-bit words; byte span is MemWords*8.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- awaddr_i  in  AxiAddrWidth  write address
- awburst_i  in  2  0=FIXED 1=INCR 2=WRAP
- awsize_i  in  3  beat size log2 bytes
- awlen_i  in  8  beats-1
- awid_i  in  AxiIdWidth  write ID
- awvalid_i  in  1 / awready_o  out  1  AW handshake
- wdata_i  in  64  write data
- wstrb_i  in  8  byte enables
- wlast_i  in  1  last write beat
- wvalid_i  in  1 / wready_o  out  1  W handshake
- bresp_o  out  2  write response
- bid_o  out  AxiIdWidth  echoed awid
- bvalid_o  out  1 / bready_i  in  1  B handshake
- araddr_i  in  AxiAddrWidth  read address
- arburst_i  in  2 / arsize_i  in  3 / arlen_i  in  8  read burst attributes
- arid_i  in  AxiIdWidth  read ID
- arvalid_i  in  1 / arready_o  out  1  AR handshake
- rdata_o  out  64  read data
- rresp_o  out  2  read response
- rid_o  out  AxiIdWidth  echoed arid
- rlast_o  out  1  last read beat
- rvalid_o  out  1 / rready_i  in  1  R handshake

Behaviour:
- Reset values:
  - awready_o=1, arready_o=1.
  - wready_o=0, bvalid_o=0, rvalid_o=0, rlast_o=0.
  - bresp_o/rresp_o/bid_o/rid_o/rdata_o=0.
  - Both FSMs return to IDLE.
  - RAM contents are not cleared.
- Reset mid-burst: abandon the burst immediately; no further beats, no B/R response.
- Write FSM:
  - W_IDLE: awready_o=1. AW handshake captures addr/burst/size/len/id, clears the error flag, moves to W_DATA. awready_o=0 outside W_IDLE.
  - W_DATA: wready_o=1. Each W handshake writes the bytes enabled by wstrb_i to RAM word addr[..:3], then advances the address. The beat with the captured len count moves to W_RESP.
  - W_DATA, wlast mismatch: wlast_i asserted early, or missing on the final beat, sets the error flag. Termination is by beat count only.
  - W_RESP: bvalid_o=1, bid_o=captured id, bresp_o=SLVERR(2) if the error flag is set, else OKAY(0). On bready_i, return to W_IDLE; awready_o is high again on the next cycle.
- Read FSM:
  - R_IDLE: arready_o=1. AR handshake captures attributes, moves to R_DATA.
  - R_DATA: rvalid_o rises the cycle after the AR handshake (1-cycle RAM latency). rid_o=captured id; rlast_o=1 on beat len.
  - R_DATA, stall: rdata/rresp/rlast hold stable while rvalid_o=1 and rready_i=0.
  - R_DATA, beats: next beat is valid on the cycle after each handshake (one beat per 2 cycles maximum is acceptable; back-to-back beats are preferred). After the last handshake, return to R_IDLE.
- Address generation (per beat, step = 1<<size):
  - FIXED: address unchanged.
  - INCR: next = (addr & ~(step-1)) + step.
  - WRAP: boundary = (len+1)*step; next = start_base + ((addr + step) mod boundary), where start_base = addr aligned down to boundary.
- Errors (response SLVERR):
  - Read beat errors: rdata_o=0 for that beat; other beats respond normally.
  - Write beat errors: the RAM write for that beat is suppressed and the error flag is set.
  - Beat error conditions: word index >= MemWords; size>3; WRAP with len not in {1,3,7,15}; burst=3 (reserved).
- Exclusive access: lock is not supported; always OKAY, never EXOKAY.
- Collision: a read and a write to the same word in the same cycle → the read returns pre-write data.
- Narrow transfers: the write uses wstrb_i as-is; the read returns the full 64-bit word.

Test Plan:
- Single INCR write awaddr=0x100, len=0, wdata=0x1122334455667788, wstrb=0xFF → bresp=0, bid=awid; then read araddr=0x100 len=0 → rdata=0x1122334455667788, rresp=0, rlast=1.
- INCR 4-beat write at 0x200 (data 1,2,3,4), then 4-beat read with rready toggling every cycle → rdata 1,2,3,4 in order, held stable during stalls, rlast only on beat 4.
- WRAP len=3 size=3 read starting at 0x318 over words 0x300..0x318 = A,B,C,D → beats D,A,B,C.
- Write wstrb=0x0F data 0xFFFFFFFF_FFFFFFFF to a word holding 0 → read returns 0x00000000_FFFFFFFF.
- Read len=1 at (MemWords*8-8) → beat0 OKAY with data, beat1 SLVERR with rdata=0. Write to an out-of-range address → bresp=2 and no RAM change.
- Assert rst_i during beat 2 of a 4-beat read → rvalid_o=0 the next cycle, arready_o=1; a new AR is accepted immediately.

Source files
------------

// File: rtl/axi_sub_mem_if.sv
// AXI4 subordinate bus bundle for axi_sub_mem (AW/W/B/AR/R channels).
interface axi_sub_mem_if #(
   parameter int unsigned AxiAddrWidth = 20,
   parameter int unsigned AxiDataWidth = 64,
   parameter int unsigned AxiIdWidth   = 4
);
   localparam int unsigned StrbWidth = AxiDataWidth / 8;

   // write address channel
   logic [AxiAddrWidth-1:0] awaddr_i;
   logic [1:0]              awburst_i;
   logic [2:0]              awsize_i;
   logic [7:0]              awlen_i;
   logic [AxiIdWidth-1:0]   awid_i;
   logic                    awvalid_i;
   logic                    awready_o;
   // write data channel
   logic [AxiDataWidth-1:0] wdata_i;
   logic [StrbWidth-1:0]    wstrb_i;
   logic                    wlast_i;
   logic                    wvalid_i;
   logic                    wready_o;
   // write response channel
   logic [1:0]              bresp_o;
   logic [AxiIdWidth-1:0]   bid_o;
   logic                    bvalid_o;
   logic                    bready_i;
   // read address channel
   logic [AxiAddrWidth-1:0] araddr_i;
   logic [1:0]              arburst_i;
   logic [2:0]              arsize_i;
   logic [7:0]              arlen_i;
   logic [AxiIdWidth-1:0]   arid_i;
   logic                    arvalid_i;
   logic                    arready_o;
   // read data channel
   logic [AxiDataWidth-1:0] rdata_o;
   logic [1:0]              rresp_o;
   logic [AxiIdWidth-1:0]   rid_o;
   logic                    rlast_o;
   logic                    rvalid_o;
   logic                    rready_i;

   modport slave (
      input  awaddr_i, awburst_i, awsize_i, awlen_i, awid_i, awvalid_i,
      output awready_o,
      input  wdata_i, wstrb_i, wlast_i, wvalid_i,
      output wready_o,
      output bresp_o, bid_o, bvalid_o,
      input  bready_i,
      input  araddr_i, arburst_i, arsize_i, arlen_i, arid_i, arvalid_i,
      output arready_o,
      output rdata_o, rresp_o, rid_o, rlast_o, rvalid_o,
      input  rready_i
   );

   modport master (
      output awaddr_i, awburst_i, awsize_i, awlen_i, awid_i, awvalid_i,
      input  awready_o,
      output wdata_i, wstrb_i, wlast_i, wvalid_i,
      input  wready_o,
      input  bresp_o, bid_o, bvalid_o,
      output bready_i,
      output araddr_i, arburst_i, arsize_i, arlen_i, arid_i, arvalid_i,
      input  arready_o,
      input  rdata_o, rresp_o, rid_o, rlast_o, rvalid_o,
      output rready_i
   );
endinterface

// File: rtl/axi_sub_mem.sv
// AXI4 subordinate memory model: independent read/write FSMs over a word RAM,
// one outstanding burst per channel, SLVERR on illegal or out-of-range beats.
module axi_sub_mem #(
   parameter int unsigned AxiAddrWidth = 20,
   parameter int unsigned AxiDataWidth = 64,
   parameter int unsigned AxiIdWidth   = 4,
   parameter int unsigned MemWords     = 1024
) (
   input logic          clk_i,
   input logic          rst_i,
   axi_sub_mem_if.slave bus
);
   localparam int unsigned AW   = AxiAddrWidth;
   localparam int unsigned DW   = AxiDataWidth;
   localparam int unsigned IW   = AxiIdWidth;
   localparam int unsigned SW   = DW / 8;
   localparam int unsigned IdxW = $clog2(MemWords);

   localparam logic [1:0] BurstFixed = 2'd0;
   localparam logic [1:0] BurstIncr  = 2'd1;
   localparam logic [1:0] BurstWrap  = 2'd2;
   localparam logic [1:0] BurstRsvd  = 2'd3;
   localparam logic [1:0] RespOkay   = 2'd0;
   localparam logic [1:0] RespSlverr = 2'd2;

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
   typedef enum logic       {R_IDLE, R_DATA} r_state_e;

   // captured burst attributes; addr tracks the current beat address
   typedef struct packed {
      logic [AW-1:0] addr;
      logic [1:0]    burst;
      logic [2:0]    size;
      logic [7:0]    len;
      logic [IW-1:0] id;
   } burst_t;

   logic [DW-1:0] mem [MemWords];

   // address of the beat following addr for the given burst attributes
   function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] addr,
                                               input logic [1:0]    burst,
                                               input logic [2:0]    size,
                                               input logic [7:0]    len);
      logic [AW-1:0] step;
      logic [AW-1:0] bound;
      logic [AW-1:0] base;
      step  = AW'(1) << size;
      bound = AW'({1'b0, len} + 9'd1) << size;
      base  = addr & ~(bound - AW'(1));
      case (burst)
         BurstFixed: next_addr = addr;
         BurstIncr:  next_addr = (addr & ~(step - AW'(1))) + step;
         BurstWrap:  next_addr = base + ((addr + step) & (bound - AW'(1)));
         default:    next_addr = addr;
      endcase
   endfunction

   // beat is illegal: outside the RAM, oversize, bad wrap length or reserved burst
   function automatic logic beat_err(input logic [AW-1:0] addr,
                                     input logic [1:0]    burst,
                                     input logic [2:0]    size,
                                     input logic [7:0]    len);
      logic bad_wrap;
      bad_wrap = (burst == BurstWrap) &&
                 !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
      beat_err = (32'(addr[AW-1:3]) >= MemWords) || (size > 3'd3) ||
                 (burst == BurstRsvd) || bad_wrap;
   endfunction

   // ---------------------------------------------------------------- write side
   w_state_e            w_state;
   burst_t              wb;
   logic [7:0]          w_cnt;
   logic                w_err;
   logic                w_hs_c;
   logic                w_beat_err_c;
   logic                w_last_bad_c;
   logic                w_we_c;
   logic [IdxW-1:0]     w_idx_c;

   // write beat qualification and RAM write enable
   always_comb begin
      w_hs_c       = bus.wvalid_i && bus.wready_o;
      w_beat_err_c = beat_err(wb.addr, wb.burst, wb.size, wb.len);
      w_last_bad_c = bus.wlast_i != (w_cnt == wb.len);
      w_idx_c      = wb.addr[IdxW+2:3];
      w_we_c       = !rst_i && (w_state == W_DATA) && w_hs_c && !w_beat_err_c;
   end

   // byte-enabled RAM write; contents survive reset
   always_ff @(posedge clk_i) begin
      if (w_we_c) begin
         for (int b = 0; b < SW; b++) begin
            if (bus.wstrb_i[b]) mem[w_idx_c][b*8 +: 8] <= bus.wdata_i[b*8 +: 8];
         end
      end
   end

   // write FSM: AW capture, beat-counted data phase, B response
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         w_state       <= W_IDLE;
         wb            <= '0;
         w_cnt         <= '0;
         w_err         <= 1'b0;
         bus.awready_o <= 1'b1;
         bus.wready_o  <= 1'b0;
         bus.bvalid_o  <= 1'b0;
         bus.bresp_o   <= RespOkay;
         bus.bid_o     <= '0;
      end else begin
         case (w_state)
            W_IDLE: begin
               if (bus.awvalid_i && bus.awready_o) begin
                  wb <= '{addr: bus.awaddr_i, burst: bus.awburst_i, size: bus.awsize_i,
                          len: bus.awlen_i, id: bus.awid_i};
                  w_cnt         <= '0;
                  w_err         <= 1'b0;
                  bus.awready_o <= 1'b0;
                  bus.wready_o  <= 1'b1;
                  w_state       <= W_DATA;
               end
            end
            W_DATA: begin
               if (w_hs_c) begin
                  wb.addr <= next_addr(wb.addr, wb.burst, wb.size, wb.len);
                  w_cnt   <= w_cnt + 8'd1;
                  if (w_cnt == wb.len) begin
                     bus.wready_o <= 1'b0;
                     bus.bvalid_o <= 1'b1;
                     bus.bid_o    <= wb.id;
                     bus.bresp_o  <= (w_err || w_beat_err_c || w_last_bad_c) ? RespSlverr
                                                                            : RespOkay;
                     w_state      <= W_RESP;
                  end else begin
                     w_err <= w_err || w_beat_err_c || w_last_bad_c;
                  end
               end
            end
            W_RESP: begin
               if (bus.bready_i) begin
                  bus.bvalid_o  <= 1'b0;
                  bus.awready_o <= 1'b1;
                  w_state       <= W_IDLE;
               end
            end
            default: w_state <= W_IDLE;
         endcase
      end
   end

   // ----------------------------------------------------------------- read side
   r_state_e            r_state;
   burst_t              rb;
   logic [7:0]          r_cnt;
   logic [AW-1:0]       r_nxt_c;
   logic [AW-1:0]       r_ld_addr_c;
   logic                r_ld_err_c;
   logic [IdxW-1:0]     r_ld_idx_c;

   // address of the beat to load: the AR address when idle, else the next beat
   always_comb begin
      r_nxt_c     = next_addr(rb.addr, rb.burst, rb.size, rb.len);
      r_ld_addr_c = r_nxt_c;
      r_ld_err_c  = beat_err(r_nxt_c, rb.burst, rb.size, rb.len);
      if (r_state == R_IDLE) begin
         r_ld_addr_c = bus.araddr_i;
         r_ld_err_c  = beat_err(bus.araddr_i, bus.arburst_i, bus.arsize_i, bus.arlen_i);
      end
      r_ld_idx_c = r_ld_addr_c[IdxW+2:3];
   end

   // read FSM: beat data is loaded on AR accept and on each R handshake
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state       <= R_IDLE;
         rb            <= '0;
         r_cnt         <= '0;
         bus.arready_o <= 1'b1;
         bus.rvalid_o  <= 1'b0;
         bus.rlast_o   <= 1'b0;
         bus.rdata_o   <= '0;
         bus.rresp_o   <= RespOkay;
         bus.rid_o     <= '0;
      end else begin
         case (r_state)
            R_IDLE: begin
               if (bus.arvalid_i && bus.arready_o) begin
                  rb <= '{addr: bus.araddr_i, burst: bus.arburst_i, size: bus.arsize_i,
                          len: bus.arlen_i, id: bus.arid_i};
                  r_cnt         <= '0;
                  bus.arready_o <= 1'b0;
                  bus.rvalid_o  <= 1'b1;
                  bus.rid_o     <= bus.arid_i;
                  bus.rlast_o   <= (bus.arlen_i == 8'd0);
                  bus.rdata_o   <= r_ld_err_c ? '0 : mem[r_ld_idx_c];
                  bus.rresp_o   <= r_ld_err_c ? RespSlverr : RespOkay;
                  r_state       <= R_DATA;
               end
            end
            R_DATA: begin
               if (bus.rvalid_o && bus.rready_i) begin
                  if (bus.rlast_o) begin
                     bus.rvalid_o  <= 1'b0;
                     bus.rlast_o   <= 1'b0;
                     bus.arready_o <= 1'b1;
                     r_state       <= R_IDLE;
                  end else begin
                     rb.addr     <= r_nxt_c;
                     r_cnt       <= r_cnt + 8'd1;
                     bus.rlast_o <= (8'(r_cnt + 8'd1) == rb.len);
                     bus.rdata_o <= r_ld_err_c ? '0 : mem[r_ld_idx_c];
                     bus.rresp_o <= r_ld_err_c ? RespSlverr : RespOkay;
                  end
               end
            end
            default: r_state <= R_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_axi_sub_mem.sv
// Directed self-checking bench for axi_sub_mem.
module tb_axi_sub_mem;
   logic clk;
   logic rst;
   int   tests;
   int   fails;

   axi_sub_mem_if bus ();

   axi_sub_mem dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // write stimulus and read capture buffers
   logic [63:0] wdat [16];
   logic [7:0]  wstb [16];
   logic [63:0] rd   [16];
   logic [1:0]  rr   [16];
   logic        rl   [16];
   logic [3:0]  rid_s[16];
   logic [1:0]  b_resp;
   logic [3:0]  b_id;
   int          ar_wait, rd_lat, rd_cycles, stall_seen, stall_changes;

   task automatic axi_write(input logic [19:0] addr, input logic [1:0] burst,
                            input logic [2:0] size, input logic [7:0] len,
                            input logic [3:0] id, input bit bad_last);
      int n;
      bus.awaddr_i = addr; bus.awburst_i = burst; bus.awsize_i = size;
      bus.awlen_i = len; bus.awid_i = id; bus.awvalid_i = 1'b1;
      n = 0;
      while (bus.awready_o !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
      if (n >= 50) begin tests++; fails++; $display("FAIL aw_timeout addr=%h", addr); end
      @(posedge clk); #1;
      bus.awvalid_i = 1'b0;
      for (int i = 0; i <= int'(len); i++) begin
         bus.wdata_i = wdat[i]; bus.wstrb_i = wstb[i]; bus.wvalid_i = 1'b1;
         bus.wlast_i = bad_last ? (i == 0) : (i == int'(len));
         n = 0;
         while (bus.wready_o !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
         if (n >= 50) begin tests++; fails++; $display("FAIL w_timeout beat=%0d", i); end
         @(posedge clk); #1;
      end
      bus.wvalid_i = 1'b0; bus.wlast_i = 1'b0;
      bus.bready_i = 1'b1;
      n = 0;
      while (bus.bvalid_o !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
      if (n >= 50) begin tests++; fails++; $display("FAIL b_timeout addr=%h", addr); end
      b_resp = bus.bresp_o; b_id = bus.bid_o;
      @(posedge clk); #1;
      bus.bready_i = 1'b0;
   endtask

   task automatic axi_read(input logic [19:0] addr, input logic [1:0] burst,
                           input logic [2:0] size, input logic [7:0] len,
                           input logic [3:0] id, input bit stall);
      int n, beats, cyc;
      bit have_hold;
      logic [66:0] hold;
      bus.araddr_i = addr; bus.arburst_i = burst; bus.arsize_i = size;
      bus.arlen_i = len; bus.arid_i = id; bus.arvalid_i = 1'b1;
      n = 0;
      while (bus.arready_o !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
      if (n >= 50) begin tests++; fails++; $display("FAIL ar_timeout addr=%h", addr); end
      ar_wait = n;
      @(posedge clk); #1;
      bus.arvalid_i = 1'b0;
      rd_lat = 0;
      while (bus.rvalid_o !== 1'b1 && rd_lat < 50) begin @(posedge clk); #1; rd_lat++; end
      beats = 0; cyc = 0; have_hold = 1'b0; hold = '0;
      stall_seen = 0; stall_changes = 0;
      while (beats <= int'(len) && cyc < 200) begin
         bus.rready_i = stall ? (cyc % 2 == 1) : 1'b1;
         if (bus.rvalid_o === 1'b1) begin
            if (have_hold && {bus.rdata_o, bus.rresp_o, bus.rlast_o} !== hold) stall_changes++;
            if (!bus.rready_i) begin
               hold = {bus.rdata_o, bus.rresp_o, bus.rlast_o};
               have_hold = 1'b1;
               stall_seen++;
            end else begin
               rd[beats] = bus.rdata_o; rr[beats] = bus.rresp_o;
               rl[beats] = bus.rlast_o; rid_s[beats] = bus.rid_o;
               beats++;
               have_hold = 1'b0;
            end
         end
         @(posedge clk); #1;
         cyc++;
      end
      rd_cycles = cyc;
      bus.rready_i = 1'b0;
      if (beats <= int'(len)) begin
         tests++; fails++; $display("FAIL r_timeout got %0d beats exp %0d", beats, int'(len) + 1);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      tests++;
      if ({bus.awready_o, bus.arready_o} !== 2'b11) begin
         fails++; $display("FAIL reset_ready got %b exp 11", {bus.awready_o, bus.arready_o});
      end
      tests++;
      if ({bus.wready_o, bus.bvalid_o, bus.rvalid_o, bus.rlast_o} !== 4'b0000) begin
         fails++; $display("FAIL reset_valids got %b exp 0000",
                           {bus.wready_o, bus.bvalid_o, bus.rvalid_o, bus.rlast_o});
      end
      tests++;
      if ({bus.bresp_o, bus.rresp_o, bus.bid_o, bus.rid_o, bus.rdata_o} !== 76'd0) begin
         fails++; $display("FAIL reset_payload got %h exp 0",
                           {bus.bresp_o, bus.rresp_o, bus.bid_o, bus.rid_o, bus.rdata_o});
      end
   endtask

   task automatic test_single();
      wdat[0] = 64'h1122334455667788; wstb[0] = 8'hFF;
      axi_write(20'h100, 2'd1, 3'd3, 8'd0, 4'd5, 1'b0);
      tests++;
      if ({b_resp, b_id} !== {2'd0, 4'd5}) begin
         fails++; $display("FAIL single_b got resp=%0d id=%0d exp resp=0 id=5", b_resp, b_id);
      end
      axi_read(20'h100, 2'd1, 3'd3, 8'd0, 4'd3, 1'b0);
      tests++;
      if (rd[0] !== 64'h1122334455667788) begin
         fails++; $display("FAIL single_rdata got %h exp 1122334455667788", rd[0]);
      end
      tests++;
      if ({rr[0], rl[0], rid_s[0]} !== {2'd0, 1'b1, 4'd3}) begin
         fails++; $display("FAIL single_rattr got resp=%0d last=%0d id=%0d exp 0 1 3",
                           rr[0], rl[0], rid_s[0]);
      end
      tests++;
      if (rd_lat !== 0) begin
         fails++; $display("FAIL single_latency got %0d exp 0", rd_lat);
      end
   endtask

   task automatic test_incr_stall();
      for (int i = 0; i < 4; i++) begin wdat[i] = 64'(i + 1); wstb[i] = 8'hFF; end
      axi_write(20'h200, 2'd1, 3'd3, 8'd3, 4'd1, 1'b0);
      tests++;
      if (b_resp !== 2'd0) begin fails++; $display("FAIL incr_bresp got %0d exp 0", b_resp); end
      axi_read(20'h200, 2'd1, 3'd3, 8'd3, 4'd2, 1'b1);
      for (int i = 0; i < 4; i++) begin
         tests++;
         if (rd[i] !== 64'(i + 1) || rl[i] !== (i == 3) || rr[i] !== 2'd0) begin
            fails++; $display("FAIL incr_beat%0d got data=%h last=%0d resp=%0d exp data=%0d last=%0d resp=0",
                              i, rd[i], rl[i], rr[i], i + 1, i == 3);
         end
      end
      tests++;
      if (stall_seen == 0 || stall_changes != 0) begin
         fails++; $display("FAIL incr_stall_hold got stalls=%0d changes=%0d exp stalls>0 changes=0",
                           stall_seen, stall_changes);
      end
   endtask

   task automatic test_back_to_back();
      axi_read(20'h200, 2'd1, 3'd3, 8'd3, 4'd7, 1'b0);
      tests++;
      if (rd_cycles !== 4) begin
         fails++; $display("FAIL b2b_cycles got %0d exp 4", rd_cycles);
      end
      tests++;
      if ({rd[0][3:0], rd[1][3:0], rd[2][3:0], rd[3][3:0]} !== 16'h1234) begin
         fails++; $display("FAIL b2b_data got %h exp 1234",
                           {rd[0][3:0], rd[1][3:0], rd[2][3:0], rd[3][3:0]});
      end
   endtask

   task automatic test_wrap();
      wdat[0] = 64'hA; wdat[1] = 64'hB; wdat[2] = 64'hC; wdat[3] = 64'hD;
      for (int i = 0; i < 4; i++) wstb[i] = 8'hFF;
      axi_write(20'h300, 2'd1, 3'd3, 8'd3, 4'd0, 1'b0);
      axi_read(20'h318, 2'd2, 3'd3, 8'd3, 4'd4, 1'b0);
      tests++;
      if ({rd[0][3:0], rd[1][3:0], rd[2][3:0], rd[3][3:0]} !== 16'hDABC) begin
         fails++; $display("FAIL wrap_order got %h exp dabc",
                           {rd[0][3:0], rd[1][3:0], rd[2][3:0], rd[3][3:0]});
      end
      tests++;
      if ({rr[0], rr[1], rr[2], rr[3]} !== 8'd0 || {rl[0], rl[1], rl[2], rl[3]} !== 4'b0001) begin
         fails++; $display("FAIL wrap_attr got resp=%b last=%b exp resp=0 last=0001",
                           {rr[0], rr[1], rr[2], rr[3]}, {rl[0], rl[1], rl[2], rl[3]});
      end
      axi_read(20'h300, 2'd2, 3'd3, 8'd2, 4'd4, 1'b0);
      tests++;
      if ({rr[0], rr[1], rr[2], rd[0]} !== {6'b101010, 64'd0}) begin
         fails++; $display("FAIL wrap_badlen got resp=%b data0=%h exp resp=101010 data0=0",
                           {rr[0], rr[1], rr[2]}, rd[0]);
      end
   endtask

   task automatic test_strobe();
      wdat[0] = 64'd0; wstb[0] = 8'hFF;
      axi_write(20'h400, 2'd1, 3'd3, 8'd0, 4'd0, 1'b0);
      wdat[0] = 64'hFFFFFFFF_FFFFFFFF; wstb[0] = 8'h0F;
      axi_write(20'h400, 2'd1, 3'd3, 8'd0, 4'd0, 1'b0);
      axi_read(20'h400, 2'd1, 3'd3, 8'd0, 4'd0, 1'b0);
      tests++;
      if (rd[0] !== 64'h00000000_FFFFFFFF) begin
         fails++; $display("FAIL strobe_rdata got %h exp 00000000ffffffff", rd[0]);
      end
   endtask

   task automatic test_fixed();
      wdat[0] = 64'h51; wdat[1] = 64'h52; wdat[2] = 64'h53;
      for (int i = 0; i < 3; i++) wstb[i] = 8'hFF;
      axi_write(20'h500, 2'd0, 3'd3, 8'd2, 4'd9, 1'b0);
      axi_read(20'h500, 2'd1, 3'd3, 8'd1, 4'd0, 1'b0);
      tests++;
      if (rd[0] !== 64'h53) begin fails++; $display("FAIL fixed_lastwins got %h exp 53", rd[0]); end
      tests++;
      if (rd[1] === 64'h51 || rd[1] === 64'h52 || rd[1] === 64'h53) begin
         fails++; $display("FAIL fixed_neighbour got %h exp untouched word", rd[1]);
      end
   endtask

   task automatic test_errors();
      wdat[0] = 64'hDEADBEEF_00000001; wstb[0] = 8'hFF;
      axi_write(20'h1FF8, 2'd1, 3'd3, 8'd0, 4'd0, 1'b0);
      axi_read(20'h1FF8, 2'd1, 3'd3, 8'd1, 4'd6, 1'b0);
      tests++;
      if ({rd[0], rr[0], rl[0]} !== {64'hDEADBEEF_00000001, 2'd0, 1'b0}) begin
         fails++; $display("FAIL oor_beat0 got data=%h resp=%0d last=%0d exp deadbeef00000001 0 0",
                           rd[0], rr[0], rl[0]);
      end
      tests++;
      if ({rd[1], rr[1], rl[1]} !== {64'd0, 2'd2, 1'b1}) begin
         fails++; $display("FAIL oor_beat1 got data=%h resp=%0d last=%0d exp 0 2 1",
                           rd[1], rr[1], rl[1]);
      end
      wdat[0] = 64'h0123456789ABCDEF; wstb[0] = 8'hFF;
      axi_write(20'h0, 2'd1, 3'd3, 8'd0, 4'd0, 1'b0);
      wdat[0] = 64'h5555AAAA5555AAAA;
      axi_write(20'h2000, 2'd1, 3'd3, 8'd0, 4'd8, 1'b0);
      tests++;
      if ({b_resp, b_id} !== {2'd2, 4'd8}) begin
         fails++; $display("FAIL oor_bresp got resp=%0d id=%0d exp 2 8", b_resp, b_id);
      end
      axi_read(20'h0, 2'd1, 3'd3, 8'd0, 4'd0, 1'b0);
      tests++;
      if (rd[0] !== 64'h0123456789ABCDEF) begin
         fails++; $display("FAIL oor_noalias got %h exp 0123456789abcdef", rd[0]);
      end
      wdat[0] = 64'h61; wdat[1] = 64'h62; wstb[0] = 8'hFF; wstb[1] = 8'hFF;
      axi_write(20'h600, 2'd1, 3'd3, 8'd1, 4'd0, 1'b1);
      tests++;
      if (b_resp !== 2'd2) begin fails++; $display("FAIL wlast_bresp got %0d exp 2", b_resp); end
      axi_read(20'h600, 2'd1, 3'd3, 8'd1, 4'd0, 1'b0);
      tests++;
      if ({rd[0], rd[1]} !== {64'h61, 64'h62}) begin
         fails++; $display("FAIL wlast_data got %h %h exp 61 62", rd[0], rd[1]);
      end
      axi_read(20'h100, 2'd3, 3'd3, 8'd0, 4'd0, 1'b0);
      tests++;
      if ({rd[0], rr[0]} !== {64'd0, 2'd2}) begin
         fails++; $display("FAIL rsvd_burst got data=%h resp=%0d exp 0 2", rd[0], rr[0]);
      end
      axi_read(20'h100, 2'd1, 3'd4, 8'd0, 4'd0, 1'b0);
      tests++;
      if (rr[0] !== 2'd2) begin fails++; $display("FAIL big_size got resp=%0d exp 2", rr[0]); end
   endtask

   task automatic test_reset_mid_burst();
      int n;
      bus.araddr_i = 20'h200; bus.arburst_i = 2'd1; bus.arsize_i = 3'd3;
      bus.arlen_i = 8'd3; bus.arid_i = 4'd1; bus.arvalid_i = 1'b1;
      n = 0;
      while (bus.arready_o !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
      @(posedge clk); #1;
      bus.arvalid_i = 1'b0;
      bus.rready_i = 1'b1;
      repeat (2) begin @(posedge clk); #1; end
      tests++;
      if ({bus.rvalid_o, bus.rdata_o} !== {1'b1, 64'd3}) begin
         fails++; $display("FAIL mid_beat2 got valid=%0d data=%h exp 1 3", bus.rvalid_o, bus.rdata_o);
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      bus.rready_i = 1'b0;
      tests++;
      if ({bus.rvalid_o, bus.arready_o, bus.rlast_o} !== 3'b010) begin
         fails++; $display("FAIL mid_reset got valid/arready/last=%b exp 010",
                           {bus.rvalid_o, bus.arready_o, bus.rlast_o});
      end
      axi_read(20'h100, 2'd1, 3'd3, 8'd0, 4'd2, 1'b0);
      tests++;
      if (ar_wait !== 0 || rd[0] !== 64'h1122334455667788 || rl[0] !== 1'b1) begin
         fails++; $display("FAIL mid_newar got wait=%0d data=%h last=%0d exp 0 1122334455667788 1",
                           ar_wait, rd[0], rl[0]);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      tests = 0; fails = 0;
      rst = 1'b1;
      bus.awaddr_i = '0; bus.awburst_i = '0; bus.awsize_i = '0; bus.awlen_i = '0;
      bus.awid_i = '0; bus.awvalid_i = 1'b0;
      bus.wdata_i = '0; bus.wstrb_i = '0; bus.wlast_i = 1'b0; bus.wvalid_i = 1'b0;
      bus.bready_i = 1'b0;
      bus.araddr_i = '0; bus.arburst_i = '0; bus.arsize_i = '0; bus.arlen_i = '0;
      bus.arid_i = '0; bus.arvalid_i = 1'b0; bus.rready_i = 1'b0;
      test_reset();
      test_single();
      test_incr_stall();
      test_back_to_back();
      test_wrap();
      test_strobe();
      test_fixed();
      test_errors();
      test_reset_mid_burst();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
